led_bus_master: RTL and testbench

- Bus initiator for the LED controller register bus: the requester end of the addr/data/w_en/r_en protocol that led_controller answers.
- Accepts register read/write commands from an upstream host front-end (future serial target or sequencer) through a valid/ready port and buffers them in a small FIFO.
- Replays each command as a two-cycle bus transaction (setup, strobe) and returns read data on a response port.
- Sits beside led_controller on the 400 kHz bus clock domain.

---
 rtl/led_bus_master.sv | 192 +++++++++++++++++++
 tb/tb_led_bus_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bus_master.sv
// led_bus_master: requester end of the LED controller register bus.
// Host commands (read/write) are queued in a small FIFO and replayed as
// two-cycle bus transactions (setup, strobe). Read data is returned on a
// one-cycle response pulse.
// Optional build macro LED_BUS_MASTER_VERIFY_EN: each write is followed by an
// automatic readback, and a differing value sets the sticky err flag.
module led_bus_master #(
    parameter int ADDR_BITS  = 4,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_400K,
    input  logic                 reset,
    input  logic                 sleep,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 busy,
    output logic                 err,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_wdata,
    output logic                 bus_oe,
    input  logic [DATA_BITS-1:0] bus_rdata,
    output logic                 bus_w_en,
    output logic                 bus_r_en
);

    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_BITS = 1 + ADDR_BITS + DATA_BITS;
    localparam logic [PTR_BITS:0] PTR_ONE = 1;

`ifdef LED_BUS_MASTER_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, RESP, VSETUP, VSTROBE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, SETUP, STROBE, RESP
    } state_t;
`endif

    state_t state_reg;
    state_t state_next;

    // Command FIFO: entry = {write, addr, wdata}. Pointers carry one extra
    // wrap bit so full and empty can be told apart without a counter.
    logic [ENTRY_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS:0]     wr_ptr_reg;
    logic [PTR_BITS:0]     rd_ptr_reg;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    // Command currently being replayed on the bus.
    logic                  hold_write_reg;
    logic [ADDR_BITS-1:0]  hold_addr_reg;
    logic [DATA_BITS-1:0]  hold_wdata_reg;

    logic [DATA_BITS-1:0]  rsp_data_reg;
    logic                  capture_rsp;

`ifdef LED_BUS_MASTER_VERIFY_EN
    logic                  err_reg;
    logic                  capture_verify;
`endif

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_BITS] != rd_ptr_reg[PTR_BITS]) &&
                        (wr_ptr_reg[PTR_BITS-1:0] == rd_ptr_reg[PTR_BITS-1:0]);

    // Held low while reset is asserted so every output reads 0 during reset.
    assign cmd_ready = !fifo_full && !reset;
    assign push      = cmd_valid && cmd_ready;

    assign busy      = !fifo_empty || (state_reg != IDLE);
    assign bus_addr  = hold_addr_reg;
    assign bus_wdata = hold_wdata_reg;
    assign bus_oe    = bus_w_en;
    assign rsp_data  = rsp_data_reg;

`ifdef LED_BUS_MASTER_VERIFY_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // FIFO storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk_400K) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_BITS-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers, FSM state, holding registers and response capture.
    always_ff @(posedge clk_400K or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            hold_write_reg <= 1'b0;
            hold_addr_reg  <= '0;
            hold_wdata_reg <= '0;
            rsp_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                {hold_write_reg, hold_addr_reg, hold_wdata_reg} <=
                    fifo_mem[rd_ptr_reg[PTR_BITS-1:0]];
            end
            if (capture_rsp) begin
                rsp_data_reg <= bus_rdata;
            end
        end
    end

`ifdef LED_BUS_MASTER_VERIFY_EN
    // Sticky mismatch flag from the post-write readback.
    always_ff @(posedge clk_400K or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (capture_verify && (bus_rdata != hold_wdata_reg)) begin
            err_reg <= 1'b1;
        end
    end
`endif

    // Next-state and strobe decode; strobes come straight from the state so
    // an asynchronous reset removes them at once.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        bus_w_en    = 1'b0;
        bus_r_en    = 1'b0;
        rsp_valid   = 1'b0;
        capture_rsp = 1'b0;
`ifdef LED_BUS_MASTER_VERIFY_EN
        capture_verify = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !sleep) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = STROBE;
            end
            STROBE: begin
                if (hold_write_reg) begin
                    bus_w_en = 1'b1;
`ifdef LED_BUS_MASTER_VERIFY_EN
                    state_next = VSETUP;
`else
                    state_next = IDLE;
`endif
                end else begin
                    bus_r_en    = 1'b1;
                    capture_rsp = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
`ifdef LED_BUS_MASTER_VERIFY_EN
            VSETUP: begin
                state_next = VSTROBE;
            end
            VSTROBE: begin
                bus_r_en       = 1'b1;
                capture_verify = 1'b1;
                state_next     = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_led_bus_master.sv
// Testbench for led_bus_master with a simple register-file bus target.
// Address 0xF of the target is read-only and always returns 0x5A.
`timescale 1ns/1ps
module tb_led_bus_master;

    localparam logic [3:0] PWM0   = 4'h2;
    localparam logic [3:0] PWM1   = 4'h3;
    localparam logic [3:0] GRPPWM = 4'h6;
    localparam logic [3:0] RO_REG = 4'hF;

    logic       clk_400K = 1'b0;
    logic       reset    = 1'b1;
    logic       sleep    = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr  = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       err;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_oe;
    logic [7:0] bus_rdata;
    logic       bus_w_en;
    logic       bus_r_en;

    led_bus_master #(.ADDR_BITS(4), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk_400K (clk_400K),
        .reset    (reset),
        .sleep    (sleep),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .err      (err),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_oe   (bus_oe),
        .bus_rdata(bus_rdata),
        .bus_w_en (bus_w_en),
        .bus_r_en (bus_r_en)
    );

    // 400 kHz bus clock
    always #1250 clk_400K = ~clk_400K;

    int checks   = 0;
    int failures = 0;

    // Bus target model and transaction monitors
    logic [7:0] slave_mem [16];
    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    wr_t wr_log[$];
    int  rsp_cnt  = 0;
    logic [7:0] last_rsp = '0;
    logic overlap_seen = 1'b0;
    logic oe_bad_seen  = 1'b0;

    assign bus_rdata = (bus_addr == RO_REG) ? 8'h5A : slave_mem[bus_addr];

    // Target register writes, logging and strobe sanity monitoring
    always @(posedge clk_400K) begin
        if (bus_w_en) begin
            if (bus_addr != RO_REG) slave_mem[bus_addr] <= bus_wdata;
            wr_log.push_back('{a: bus_addr, d: bus_wdata});
            $display("bus write addr=0x%0h data=0x%02h", bus_addr, bus_wdata);
        end
        if (bus_r_en) $display("bus read  addr=0x%0h data=0x%02h", bus_addr, bus_rdata);
        if (bus_w_en && bus_r_en) overlap_seen <= 1'b1;
        if (bus_oe != bus_w_en) oe_bad_seen <= 1'b1;
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            last_rsp <= rsp_data;
            $display("response data=0x%02h", rsp_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_400K);
        #1;
    endtask

    // Offer one command; returns 1 ns after the accepting edge.
    task automatic push(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("push_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin tick(); n++; end
        check(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rsp;
    } vec_t;
    vec_t vecs [7];

    initial begin
        int base;
        int r0;
        for (int i = 0; i < 16; i++) slave_mem[i] = 8'h00;

        // Vector table: writes then reads with hand-computed expectations
        vecs[0] = '{wr: 1'b1, addr: 4'h5, wdata: 8'h11, exp_rsp: 8'h00};
        vecs[1] = '{wr: 1'b1, addr: 4'h6, wdata: 8'h22, exp_rsp: 8'h00};
        vecs[2] = '{wr: 1'b0, addr: 4'h5, wdata: 8'h00, exp_rsp: 8'h11};
        vecs[3] = '{wr: 1'b0, addr: 4'h6, wdata: 8'h00, exp_rsp: 8'h22};
        vecs[4] = '{wr: 1'b1, addr: 4'h5, wdata: 8'hA5, exp_rsp: 8'h00};
        vecs[5] = '{wr: 1'b0, addr: 4'h5, wdata: 8'h00, exp_rsp: 8'hA5};
        vecs[6] = '{wr: 1'b0, addr: PWM0, wdata: 8'h00, exp_rsp: 8'h40};

        // Reset state
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({bus_w_en, bus_r_en, bus_oe, rsp_valid}), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write PWM0=0x40: latency and single-cycle strobe
        push(1'b1, PWM0, 8'h40);
        check("wr_busy_rise", 32'(busy), 32'd1);
        tick();
        check("wr_setup_addr", 32'(bus_addr), 32'(PWM0));
        check("wr_setup_data", 32'(bus_wdata), 32'h40);
        check("wr_setup_wen", 32'(bus_w_en), 32'd0);
        tick();
        check("wr_strobe_wen", 32'(bus_w_en), 32'd1);
        check("wr_strobe_oe", 32'(bus_oe), 32'd1);
        tick();
        check("wr_strobe_one_cycle", 32'(bus_w_en), 32'd0);
        wait_idle("wr_idle");
        check("wr_target_pwm0", 32'(slave_mem[PWM0]), 32'h40);

        // Read PWM1 after writing 0x80
        push(1'b1, PWM1, 8'h80);
        wait_idle("rd_prep_idle");
        push(1'b0, PWM1, 8'h00);
        tick();
        check("rd_setup_ren", 32'(bus_r_en), 32'd0);
        tick();
        check("rd_strobe_ren", 32'(bus_r_en), 32'd1);
        check("rd_strobe_wen", 32'(bus_w_en), 32'd0);
        tick();
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(rsp_data), 32'h80);
        check("rd_ren_dropped", 32'(bus_r_en), 32'd0);
        tick();
        check("rd_rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("rd_rsp_data_held", 32'(rsp_data), 32'h80);

        // Table-driven command sequence
        for (int i = 0; i < 7; i++) begin
            r0 = rsp_cnt;
            push(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            wait_idle($sformatf("vec%0d_idle", i));
            if (vecs[i].wr) begin
                check($sformatf("vec%0d_target", i), 32'(slave_mem[vecs[i].addr]), 32'(vecs[i].wdata));
                check($sformatf("vec%0d_no_rsp", i), 32'(rsp_cnt - r0), 32'd0);
            end else begin
                check($sformatf("vec%0d_rsp_cnt", i), 32'(rsp_cnt - r0), 32'd1);
                check($sformatf("vec%0d_rsp_data", i), 32'(last_rsp), 32'(vecs[i].exp_rsp));
            end
        end

        // Fill the FIFO under sleep, then drain five writes in order
        base = wr_log.size();
        sleep = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 4'(8 + i), 8'(8'h81 + i));
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        tick(); tick(); tick();
        check("sleep_no_strobe", 32'(wr_log.size() - base), 32'd0);
        check("full_still", 32'(cmd_ready), 32'd0);
        sleep = 1'b0;
        tick();
        check("first_pop_ready", 32'(cmd_ready), 32'd1);
        push(1'b1, 4'hC, 8'h85);
        wait_idle("five_idle");
        check("five_count", 32'(wr_log.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < wr_log.size()) begin
                check($sformatf("five%0d_addr", i), 32'(wr_log[base + i].a), 32'(8 + i));
                check($sformatf("five%0d_data", i), 32'(wr_log[base + i].d), 32'(8'h81 + i));
            end
        end

        // Two commands queued under sleep, released together
        base = wr_log.size();
        r0 = rsp_cnt;
        sleep = 1'b1;
        push(1'b1, 4'hD, 8'h3C);
        push(1'b0, 4'hD, 8'h00);
        tick(); tick(); tick(); tick();
        check("sleep2_no_write", 32'(wr_log.size() - base), 32'd0);
        check("sleep2_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        check("sleep2_busy", 32'(busy), 32'd1);
        sleep = 1'b0;
        wait_idle("sleep2_idle");
        check("sleep2_write", 32'(wr_log.size() - base), 32'd1);
        check("sleep2_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
        check("sleep2_rsp_data", 32'(last_rsp), 32'h3C);

        // Reset during a read strobe with a write still queued
        r0 = rsp_cnt;
        base = wr_log.size();
        push(1'b0, 4'h5, 8'h00);
        push(1'b1, 4'h7, 8'h77);
        tick();
        check("abort_in_strobe", 32'(bus_r_en), 32'd1);
        #300 reset = 1'b1;
        #1;
        check("abort_ren_async", 32'(bus_r_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        check("abort_fifo_flushed", 32'(wr_log.size() - base), 32'd0);
        check("abort_busy_after", 32'(busy), 32'd0);

`ifdef LED_BUS_MASTER_VERIFY_EN
        // Readback verification
        push(1'b1, GRPPWM, 8'hC0);
        wait_idle("ver_good_idle");
        check("ver_good_err", 32'(err), 32'd0);
        push(1'b1, RO_REG, 8'h33);
        wait_idle("ver_bad_idle");
        check("ver_bad_err", 32'(err), 32'd1);
        push(1'b1, GRPPWM, 8'h11);
        wait_idle("ver_sticky_idle");
        check("ver_err_sticky", 32'(err), 32'd1);
`else
        push(1'b1, RO_REG, 8'h33);
        wait_idle("noverify_idle");
        check("noverify_err", 32'(err), 32'd0);
        push(1'b1, GRPPWM, 8'hC0);
        wait_idle("grppwm_idle");
        check("grppwm_target", 32'(slave_mem[GRPPWM]), 32'hC0);
`endif

        check("no_strobe_overlap", 32'(overlap_seen), 32'd0);
        check("oe_tracks_wen", 32'(oe_bad_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
